// File: rtl/button_debouncer_pkg.sv
// Shared types and sizing helpers for button_debouncer.
package button_debouncer_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  // Only s1 samples the asynchronous pin; s2 is the first safe copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton conditioner: 2-FF sync, consecutive-sample debounce, rise/fall pulses.
// Optional long-press pulse enabled by defining BUTTON_DEBOUNCER_LONGPRESS_EN.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_long
);

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s2;
  logic             s;
  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             level_next, rise_next, fall_next;

  sync_2ff #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (s2)
  );

  assign s = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STABLE;
      count     <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
      btn_fall  <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      btn_level <= level_next;
      btn_rise  <= rise_next;
      btn_fall  <= fall_next;
    end
  end

  // Compare precedes increment, so the counter tops out at CNT_LAST and never wraps.
  always_comb begin
    state_next = state;
    count_next = count;
    level_next = btn_level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      STABLE: begin
        if (s != btn_level) begin
          count_next = CNT_W'(1);
          state_next = PENDING;
        end else begin
          count_next = '0;
        end
      end
      PENDING: begin
        if (s == btn_level) begin
          count_next = '0;
          state_next = STABLE;
        end else if (count == CNT_LAST) begin
          level_next = s;
          count_next = '0;
          state_next = STABLE;
          rise_next  = s;
          fall_next  = ~s;
        end else begin
          count_next = count + CNT_W'(1);
        end
      end
      default: begin
        count_next = '0;
        state_next = STABLE;
      end
    endcase
  end

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
  localparam int unsigned       HOLD_W    = cnt_width(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold;

  // Pulse on the HOLD_FIRE -> HOLD_MAX step; saturation prevents a repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= btn_level && (hold == HOLD_FIRE);
      if (!btn_level) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (DEBOUNCE_CYCLES=4, LONG_CYCLES=10).
module tb_button_debouncer;

  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 10;

  logic clk = 1'b0;
  logic rst;
  logic raw, raw_n;
  logic level, rise, fall, lng;
  logic level_n, rise_n, fall_n, lng_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (1'b0),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (raw),
    .btn_level (level),
    .btn_rise  (rise),
    .btn_fall  (fall),
    .btn_long  (lng)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (1'b1),
    .LONG_CYCLES     (LONG)
  ) dut_n (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (raw_n),
    .btn_level (level_n),
    .btn_rise  (rise_n),
    .btn_fall  (fall_n),
    .btn_long  (lng_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic v);
    raw = v;
    repeat (12) step();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    raw   = 1'b1;
    raw_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({level, rise, fall, lng} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got %b want 0000", i, {level, rise, fall, lng});
      end
    end
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      step();
      checks++;
      if (rise !== (k == 5)) begin
        errors++;
        $display("FAIL reset_release_rise k=%0d got %b want %b", k, rise, (k == 5));
      end
      checks++;
      if (level !== (k >= 5)) begin
        errors++;
        $display("FAIL reset_release_level k=%0d got %b want %b", k, level, (k >= 5));
      end
    end
  endtask

  task automatic test_clean_press();
    settle(1'b0);
    raw = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      checks++;
      if (rise !== (k == 5)) begin
        errors++;
        $display("FAIL press_rise k=%0d got %b want %b", k, rise, (k == 5));
      end
      checks++;
      if (level !== (k >= 5)) begin
        errors++;
        $display("FAIL press_level k=%0d got %b want %b", k, level, (k >= 5));
      end
      checks++;
      if (fall !== 1'b0) begin
        errors++;
        $display("FAIL press_fall k=%0d got %b want 0", k, fall);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    settle(1'b0);
    for (int k = 0; k <= 11; k++) begin
      raw = (k < 8) ? pat[k] : 1'b1;
      step();
      checks++;
      if (rise !== (k == 9)) begin
        errors++;
        $display("FAIL bounce_rise k=%0d got %b want %b", k, rise, (k == 9));
      end
      checks++;
      if (level !== (k >= 9)) begin
        errors++;
        $display("FAIL bounce_level k=%0d got %b want %b", k, level, (k >= 9));
      end
    end
  endtask

  task automatic test_active_low();
    raw_n = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      step();
      checks++;
      if ({rise_n, fall_n} !== {(k == 5), 1'b0}) begin
        errors++;
        $display("FAIL al_press_pulses k=%0d got %b want %b", k, {rise_n, fall_n}, {(k == 5), 1'b0});
      end
      checks++;
      if (level_n !== (k >= 5)) begin
        errors++;
        $display("FAIL al_press_level k=%0d got %b want %b", k, level_n, (k >= 5));
      end
    end
    raw_n = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      checks++;
      if ({rise_n, fall_n} !== {1'b0, (k == 5)}) begin
        errors++;
        $display("FAIL al_release_pulses k=%0d got %b want %b", k, {rise_n, fall_n}, {1'b0, (k == 5)});
      end
      checks++;
      if (level_n !== (k < 5)) begin
        errors++;
        $display("FAIL al_release_level k=%0d got %b want %b", k, level_n, (k < 5));
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    int rises = 0;
    settle(1'b0);
    raw = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({level, rise, fall} !== 3'b000) begin
        errors++;
        $display("FAIL midreset_outputs cyc=%0d got %b want 000", i, {level, rise, fall});
      end
    end
    rst = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      step();
      if (rise === 1'b1) rises++;
      checks++;
      if (rise !== (k == 5)) begin
        errors++;
        $display("FAIL midreset_rise k=%0d got %b want %b", k, rise, (k == 5));
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL midreset_rise_count got %0d want 1", rises);
    end
  endtask

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
  task automatic test_long_press();
    settle(1'b0);
    raw = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      step();
      checks++;
      if (lng !== (k == 15)) begin
        errors++;
        $display("FAIL long_pulse k=%0d got %b want %b", k, lng, (k == 15));
      end
    end
  endtask

  task automatic test_short_press();
    settle(1'b0);
    raw = 1'b1;
    for (int k = 0; k <= 25; k++) begin
      if (k == 6) raw = 1'b0;
      step();
      checks++;
      if (lng !== 1'b0) begin
        errors++;
        $display("FAIL short_no_long k=%0d got %b want 0", k, lng);
      end
      if (k == 5 || k == 11) begin
        checks++;
        if ({rise, fall} !== {(k == 5), (k == 11)}) begin
          errors++;
          $display("FAIL short_edges k=%0d got %b want %b", k, {rise, fall}, {(k == 5), (k == 11)});
        end
      end
    end
  endtask
`else
  task automatic test_long_tied();
    settle(1'b0);
    raw = 1'b1;
    for (int k = 0; k <= 24; k++) begin
      step();
      checks++;
      if ({lng, lng_n} !== 2'b00) begin
        errors++;
        $display("FAIL long_tied k=%0d got %b want 00", k, {lng, lng_n});
      end
    end
  endtask
`endif

  initial begin
    rst   = 1'b1;
    raw   = 1'b1;
    raw_n = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_active_low();
    test_reset_mid_pending();
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
    test_long_press();
    test_short_press();
`else
    test_long_tied();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
